// File: rtl/bash_hash_arb.sv
// bash_hash_arb -- round-robin arbiter sharing one bash_hash control unit and
// datapath between NREQ register-map requesters.
//
// A requester raises req_i and keeps it high for a whole multi-block session.
// While it owns the core, its prep/start pulses are forwarded (registered) to
// the control unit and its x/l operands are muxed onto x_o/l_o. Completion
// (cu_active_i falling) comes back as a one-cycle done_o pulse to the owner.
//
// Optional feature macro: BASH_ARB_WDOG_EN
//   Adds an idle-ownership watchdog. An owner that issues no command for
//   WDOG_CYCLES cycles in OWN loses the grant (revoke_o pulse) and is masked
//   until it drops req_i. Without the macro, revoke_o is tied low.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i               per-requester ownership request (level)
//   prep_i, start_i     per-requester command pulses
//   x_i, l_i            per-requester operands, slice k = requester k
//   gnt_o               one-hot registered grant
//   done_o              completion pulse to the owner
//   revoke_o            watchdog revoke pulse (0 without the watchdog)
//   cu_prep_o/start_o   command pulses to the control unit
//   cu_active_i         control unit busy
//   x_o, l_o            owner's operands to the datapath

package bash_hash_params_pkg;
  localparam int XLEN = 32;
  localparam int SLEN = 64;
endpackage

module bash_hash_arb
  import bash_hash_params_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           prep_i,
  input  logic [NREQ-1:0]           start_i,
  input  logic [NREQ*16*SLEN-1:0]   x_i,
  input  logic [NREQ*XLEN-1:0]      l_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           done_o,
  output logic [NREQ-1:0]           revoke_o,
  output logic                      cu_prep_o,
  output logic                      cu_start_o,
  input  logic                      cu_active_i,
  output logic [16*SLEN-1:0]        x_o,
  output logic [XLEN-1:0]           l_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int XW = 16 * SLEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ISSUE = 2'd2,
    BUSY  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     own_q, own_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              cu_prep_q, cu_prep_d;
  logic              cu_start_q, cu_start_d;

  logic [NREQ-1:0]   elig_s;
  logic [IW-1:0]     pick_s;
  logic              pick_vld_s;
  logic [IW-1:0]     idx_s;
  int                idx_v;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

`ifdef BASH_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] WDOG_LIM = CW'(WDOG_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   mask_q, mask_d;
  logic [NREQ-1:0]   revoke_q, revoke_d;

  // A revoked requester stays out of arbitration until it drops req_i.
  assign elig_s   = req_i & ~mask_q;
  assign revoke_o = revoke_q;
`else
  assign elig_s   = req_i;
  assign revoke_o = {NREQ{1'b0}};
`endif

  // Round-robin pick: scan from last+NREQ down to last+1 so the
  // closest eligible requester after last is written last and wins.
  always_comb begin
    pick_s     = last_q;
    pick_vld_s = 1'b0;
    idx_v      = 0;
    idx_s      = {IW{1'b0}};
    for (int i = NREQ; i >= 1; i--) begin
      idx_v      = (int'(last_q) + i) % NREQ;
      idx_s      = idx_v[IW-1:0];
      pick_s     = elig_s[idx_s] ? idx_s : pick_s;
      pick_vld_s = pick_vld_s | elig_s[idx_s];
    end
  end

  // Next-state and registered-output logic of the ownership FSM.
  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    done_d     = {NREQ{1'b0}};
    cu_prep_d  = 1'b0;
    cu_start_d = 1'b0;
`ifdef BASH_ARB_WDOG_EN
    cnt_d      = cnt_q;
    mask_d     = mask_q & req_i;
    revoke_d   = {NREQ{1'b0}};
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          gnt_d   = onehot(pick_s);
          own_d   = pick_s;
          state_d = OWN;
`ifdef BASH_ARB_WDOG_EN
          cnt_d   = {CW{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        // prep has priority; a simultaneous start is dropped.
        if (prep_i[own_q]) begin
          cu_prep_d = 1'b1;
          state_d   = ISSUE;
`ifdef BASH_ARB_WDOG_EN
          cnt_d     = {CW{1'b0}};
`endif
        end else if (start_i[own_q]) begin
          cu_start_d = 1'b1;
          state_d    = ISSUE;
`ifdef BASH_ARB_WDOG_EN
          cnt_d      = {CW{1'b0}};
`endif
        end else if (!req_i[own_q]) begin
          gnt_d   = {NREQ{1'b0}};
          last_d  = own_q;
          state_d = IDLE;
        end else begin
`ifdef BASH_ARB_WDOG_EN
          if ((cnt_q + CNT_ONE) == WDOG_LIM) begin
            revoke_d[own_q] = 1'b1;
            mask_d[own_q]   = 1'b1;
            gnt_d           = {NREQ{1'b0}};
            last_d          = own_q;
            state_d         = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          state_d = OWN;
`endif
        end
      end
      ISSUE: begin
        if (cu_active_i) begin
          state_d = BUSY;
        end else begin
          state_d = ISSUE;
        end
      end
      BUSY: begin
        if (!cu_active_i) begin
          done_d[own_q] = 1'b1;
          state_d       = OWN;
`ifdef BASH_ARB_WDOG_EN
          cnt_d         = {CW{1'b0}};
`endif
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {NREQ{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      own_q      <= {IW{1'b0}};
      last_q     <= IW'(NREQ - 1);
      gnt_q      <= {NREQ{1'b0}};
      done_q     <= {NREQ{1'b0}};
      cu_prep_q  <= 1'b0;
      cu_start_q <= 1'b0;
`ifdef BASH_ARB_WDOG_EN
      cnt_q      <= {CW{1'b0}};
      mask_q     <= {NREQ{1'b0}};
      revoke_q   <= {NREQ{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      cu_prep_q  <= cu_prep_d;
      cu_start_q <= cu_start_d;
`ifdef BASH_ARB_WDOG_EN
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      revoke_q   <= revoke_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign cu_prep_o  = cu_prep_q;
  assign cu_start_o = cu_start_q;

  // Owner index survives release, so operands stay stable for the core.
  assign x_o = x_i[own_q*XW +: XW];
  assign l_o = l_i[own_q*XLEN +: XLEN];

endmodule

// File: tb/tb_bash_hash_arb.sv
// Directed testbench for bash_hash_arb (NREQ=2, WDOG_CYCLES=16).
module tb_bash_hash_arb;
  import bash_hash_params_pkg::*;

  localparam int NREQ = 2;
  localparam int XW   = 16 * SLEN;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, prep, start;
  logic [NREQ*XW-1:0]    x_in;
  logic [NREQ*XLEN-1:0]  l_in;
  logic [NREQ-1:0]       gnt, done, revoke;
  logic                  cu_prep, cu_start, cu_active;
  logic [XW-1:0]         x_out;
  logic [XLEN-1:0]       l_out;

  logic [XW-1:0]         exp_x0, exp_x1;
  logic [XLEN-1:0]       exp_l0, exp_l1;

  int tests = 0;
  int fails = 0;

  bash_hash_arb #(.NREQ(NREQ), .WDOG_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .prep_i(prep), .start_i(start),
    .x_i(x_in), .l_i(l_in), .gnt_o(gnt), .done_o(done), .revoke_o(revoke),
    .cu_prep_o(cu_prep), .cu_start_o(cu_start), .cu_active_i(cu_active),
    .x_o(x_out), .l_o(l_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int w = 0; w < 16; w++) begin
      exp_x0[w*SLEN +: SLEN] = 64'h0123_4567_89AB_0000 + 64'(w);
      exp_x1[w*SLEN +: SLEN] = 64'hFEDC_BA98_7654_1000 + 64'(w);
    end
    exp_l0 = 32'h0000_0080;
    exp_l1 = 32'h0000_0100;
    x_in = {exp_x1, exp_x0};
    l_in = {exp_l1, exp_l0};
    rst = 1'b1; req = 2'b00; prep = 2'b00; start = 2'b00; cu_active = 1'b0;
    step();
    step();
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_revoke", revoke, 2'b00);
    check("rst_cu_prep", cu_prep, 1'b0);
    check("rst_cu_start", cu_start, 1'b0);
    check("rst_x", x_out, exp_x0);

    // Both request right out of reset: requester 0 first.
    rst = 1'b0; req = 2'b11;
    step();
    check("grant0", gnt, 2'b01);
    check("grant0_x", x_out, exp_x0);
    check("grant0_l", l_out, exp_l0);

    // start from owner 0
    start = 2'b01;
    step();
    start = 2'b00;
    check("start_pulse", cu_start, 1'b1);
    check("start_noprep", cu_prep, 1'b0);
    step();
    check("start_width", cu_start, 1'b0);

    // busy for 10 cycles; commands during BUSY and from non-owner ignored
    cu_active = 1'b1;
    step();
    prep = 2'b10; start = 2'b01;
    step();
    prep = 2'b00; start = 2'b00;
    check("busy_ign_prep", cu_prep, 1'b0);
    check("busy_ign_start", cu_start, 1'b0);
    check("busy_gnt", gnt, 2'b01);
    for (int c = 0; c < 8; c++) step();
    check("busy_nodone", done, 2'b00);
    cu_active = 1'b0;
    step();
    check("done_pulse", done, 2'b01);
    step();
    check("done_width", done, 2'b00);
    check("own_after_done", gnt, 2'b01);

    // non-owner prep in OWN is ignored
    prep = 2'b10;
    step();
    prep = 2'b00;
    check("nonowner_prep", cu_prep, 1'b0);
    check("nonowner_gnt", gnt, 2'b01);

    // release 0 -> 1 gets the core after one idle cycle
    req = 2'b10;
    step();
    check("rel0_gap", gnt, 2'b00);
    step();
    check("grant1", gnt, 2'b10);
    check("grant1_x", x_out, exp_x1);
    check("grant1_l", l_out, exp_l1);

    // 1 releases with 0 pending -> 0
    req = 2'b01;
    step();
    check("rel1_gap", gnt, 2'b00);
    step();
    check("rr_grant0", gnt, 2'b01);

    // 0 releases with 1 pending -> 1
    req = 2'b10;
    step();
    check("rel0b_gap", gnt, 2'b00);
    step();
    check("rr_grant1", gnt, 2'b10);

    // simultaneous prep+start from owner 1: only prep
    prep = 2'b10; start = 2'b10;
    step();
    prep = 2'b00; start = 2'b00;
    check("both_prep", cu_prep, 1'b1);
    check("both_nostart", cu_start, 1'b0);
    step();
    check("both_prep_width", cu_prep, 1'b0);
    check("both_start_later", cu_start, 1'b0);

    // reset in BUSY as activity ends: no done, everything back to reset
    cu_active = 1'b1;
    step();
    rst = 1'b1; cu_active = 1'b0;
    step();
    check("mid_rst_gnt", gnt, 2'b00);
    check("mid_rst_done", done, 2'b00);
    check("mid_rst_prep", cu_prep, 1'b0);
    check("mid_rst_start", cu_start, 1'b0);
    check("mid_rst_revoke", revoke, 2'b00);
    check("mid_rst_x", x_out, exp_x0);
    check("mid_rst_l", l_out, exp_l0);
    rst = 1'b0; req = 2'b11;
    step();
    check("post_rst_grant0", gnt, 2'b01);

`ifdef BASH_ARB_WDOG_EN
    req = 2'b01;
    for (int c = 0; c < 15; c++) step();
    check("wdog_hold_gnt", gnt, 2'b01);
    check("wdog_hold_revoke", revoke, 2'b00);
    step();
    check("wdog_revoke", revoke, 2'b01);
    check("wdog_gnt_clear", gnt, 2'b00);
    step();
    check("wdog_revoke_width", revoke, 2'b00);
    check("wdog_masked", gnt, 2'b00);
    step();
    check("wdog_masked2", gnt, 2'b00);
    req = 2'b00;
    step();
    req = 2'b01;
    step();
    check("wdog_regrant", gnt, 2'b01);
`else
    for (int c = 0; c < 20; c++) step();
    check("nowdog_hold_gnt", gnt, 2'b01);
    check("nowdog_revoke", revoke, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
